// File: rtl/mac_vec_seq_if.sv
// Handshake bundle for the MAC sequencing stage: operand stream in,
// datapath drive/result, and dot-product result stream out.
//   in_*   : operand pair stream (valid/ready)
//   mac_*  : multiplicand, multiplier, addend out; result in
//   out_*  : final sum, count, wrap flag (valid/ready)
interface mac_vec_seq_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_x;
   logic [WIDTH-1:0]     in_y;
   logic                 in_last;
   logic [WIDTH-1:0]     mac_mx;
   logic [WIDTH-1:0]     mac_my;
   logic [2*WIDTH-1:0]   mac_az;
   logic [2*WIDTH-1:0]   mac_res;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_acc;
   logic [CNT_W-1:0]     out_cnt;
   logic                 out_ovf;

   // environment side: operand source, datapath and result consumer
   modport master (
      output in_valid, in_x, in_y, in_last, mac_res, out_ready,
      input  in_ready, mac_mx, mac_my, mac_az,
      input  out_valid, out_acc, out_cnt, out_ovf
   );

   // sequencing stage side
   modport slave (
      input  in_valid, in_x, in_y, in_last, mac_res, out_ready,
      output in_ready, mac_mx, mac_my, mac_az,
      output out_valid, out_acc, out_cnt, out_ovf
   );
endinterface

// File: rtl/mac_vec_seq.sv
// Sequencing stage around a combinational MAC datapath: accepts operand
// pairs, feeds the running sum back as addend, and emits the dot product.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : mac_vec_seq_if.slave (operand in, datapath, result out)
module mac_vec_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input logic         CLK,
   input logic         RST,
   mac_vec_seq_if.slave bus
);
   localparam int AW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [AW-1:0]    acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             last_q;
   logic [WIDTH-1:0] mx;
   logic [WIDTH-1:0] my;
   logic             out_valid;
   logic [AW-1:0]    out_acc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;

   // saturating count; a result below the old sum means the add wrapped
   always_comb begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      ovf_nxt = ovf | (bus.mac_res < acc);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RUN;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         last_q    <= 1'b0;
         mx        <= '0;
         my        <= '0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_cnt   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (bus.in_valid) begin
                  mx     <= bus.in_x;
                  my     <= bus.in_y;
                  last_q <= bus.in_last;
                  state  <= MUL;
               end
            end
            MUL: begin
               if (last_q) begin
                  // publish and clear in one step for the next vector
                  out_acc   <= bus.mac_res;
                  out_cnt   <= cnt_nxt;
                  out_ovf   <= ovf_nxt;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  state     <= HOLD;
               end else begin
                  acc   <= bus.mac_res;
                  cnt   <= cnt_nxt;
                  ovf   <= ovf_nxt;
                  state <= RUN;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  state     <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.in_ready  = (state == RUN);
   assign bus.mac_mx    = mx;
   assign bus.mac_my    = my;
   assign bus.mac_az    = acc;
   assign bus.out_valid = out_valid;
   assign bus.out_acc   = out_acc;
   assign bus.out_cnt   = out_cnt;
   assign bus.out_ovf   = out_ovf;
endmodule

// File: doc/mac_vec_seq.md
Name: mac_vec_seq

Overview:
- Sequencing stage wrapped around the combinational multiply-accumulate datapath.
- Accepts a stream of operand pairs (x, y) over a valid/ready handshake and drives the datapath's multiplicand, multiplier and addend inputs.
- Captures the datapath result and feeds it back as the next addend, so a whole vector is accumulated into one dot product.
- Emits the final sum, element count and overflow flag on an output valid/ready handshake; sits directly between the operand source and the MAC datapath.

Parameters:
- WIDTH, 16, operand width; accumulator and MAC result are 2*WIDTH.
- CNT_W, 8, width of the element counter.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset (see Behaviour).
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept a pair.
- in_x  input  WIDTH  multiplicand, unsigned.
- in_y  input  WIDTH  multiplier, unsigned.
- in_last  input  1  pair is the last element of the vector.
- mac_mx  output  WIDTH  registered multiplicand to the datapath.
- mac_my  output  WIDTH  registered multiplier to the datapath.
- mac_az  output  2*WIDTH  addend to the datapath; always equals acc.
- mac_res  input  2*WIDTH  datapath result, combinational from mac_mx/mac_my/mac_az.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_acc  output  2*WIDTH  final dot product.
- out_cnt  output  CNT_W  elements accumulated.
- out_ovf  output  1  sticky wrap flag for the vector.

Behaviour:
- Reset: RST is synchronous and active-high; clock is CLK. While RST=1 at a rising edge, all registers clear: state=RUN, acc=0, cnt=0, ovf=0, last_q=0, mac_mx=0, mac_my=0, out_valid=0, out_acc=0, out_cnt=0, out_ovf=0.
- Reset mid-vector or mid-HOLD discards all partial or pending results. in_ready=1 on the first cycle after reset release.
- State RUN:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: mac_mx<=in_x, mac_my<=in_y, last_q<=in_last, go to MUL.
- State MUL:
  - in_ready=0. mac_res is stable this cycle.
  - At the end of the cycle: acc<=mac_res; cnt<=cnt+1, saturating at 2^CNT_W-1; ovf<=ovf | (mac_res < acc), an unsigned wrap test.
  - If last_q=1, go to HOLD and load out_acc=mac_res, out_cnt and out_ovf with the updated values. In the same cycle clear acc, cnt and ovf to 0 for the next vector.
  - If last_q=0, return to RUN.
- State HOLD:
  - out_valid=1, in_ready=0. out_acc, out_cnt and out_ovf stay stable until accepted.
  - On out_ready=1: go to RUN. out_valid falls and in_ready rises on the next cycle; there is no same-cycle bypass.
- Throughput and latency:
  - One element per 2 cycles.
  - A vector of N elements takes 2N cycles from the first accept to out_valid. out_valid is asserted on the cycle after the last MUL.
- Arithmetic: the datapath performs the multiply and add. The stage does no arithmetic besides the wrap compare and the counter. The sum is modulo 2^(2*WIDTH).
- Boundaries:
  - A single-element vector (in_last on the first pair) yields out_acc = x*y, out_cnt=1.
  - in_valid while in MUL or HOLD is ignored; the source must hold it.
  - in_x, in_y and in_last are sampled only on the handshake.
  - out_ready while not in HOLD is ignored.
  - Counter saturation does not affect acc.
  - mac_mx and mac_my hold their last values outside MUL.

Test Plan:
- Vector (3,4),(5,6) with last on the 2nd pair, out_ready=1 -> out_valid 4 cycles after the first accept, out_acc=42, out_cnt=2, out_ovf=0.
- Single pair (0x00FF,0x0100,last) -> out_acc=0x0000FF00, out_cnt=1. in_ready=0 during MUL and HOLD, then 1 again.
- Pairs (0xFFFF,0xFFFF) x2, last on the 2nd -> out_acc=0xFFFC0002, out_ovf=1. The next vector (1,1,last) gives out_acc=1, out_ovf=0, confirming the clear.
- Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> outputs stable, no pair accepted. Raise out_ready -> out_valid=0 next cycle, then the pair is accepted.
- Assert RST after 3 of 5 elements -> all outputs 0. A new vector (2,2,last) returns out_acc=4, out_cnt=1.
- CNT_W=2 with a 5-element vector of (1,1) -> out_acc=5, out_cnt=3 (saturated).
